r4_fft_seq: RTL and testbench
=============================

R4_FFT_SEQ -- requirements
Module: r4_fft_seq

Interface
REQ-001 SHALL have parameter DW, default 4, meaning sample width in bits for each real or imaginary part.
REQ-002 SHALL have parameter BF_LAT, default 1, meaning the butterfly's output latency in clock cycles; legal range 0..7.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: a sample is offered.
REQ-006 SHALL have port in_ready, output, 1: the sample is accepted this cycle.
REQ-007 SHALL have ports in_re and in_im, input, DW each: the offered sample.
REQ-008 SHALL have ports bf_xr and bf_xi, output, 4*DW each: the butterfly operands; x0 in bits [DW-1:0], x3 in the top DW bits.
REQ-009 SHALL have port bf_c, output, 3: the butterfly bin select {c3,c2,c1}.
REQ-010 SHALL have ports bf_xro and bf_xio, input, DW each: the butterfly results.
REQ-011 SHALL have port out_valid, output, 1: a result is presented.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have ports out_re and out_im, output, DW each: the result sample.
REQ-014 SHALL have port out_bin, output, 2: the bin index of the current result.
REQ-015 SHALL have port busy, output, 1: high in every state except LOAD.
REQ-016 SHALL have port frame_done, output, 1: a one-cycle pulse.
REQ-017 SHALL have port frame_cnt, output, 8: the count of completed frames.

Function
REQ-018 FSM states: LOAD, SETUP, WAIT, CAPTURE, DRAIN.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready handshake writes the sample into operand slot ld_idx (0..3), then ld_idx increments. The handshake on slot 3 moves the FSM to SETUP with bin=0.
REQ-020 in_ready SHALL be 0 in all states other than LOAD; in_valid is ignored there.
REQ-021 SETUP: drive bf_c from bin (bin0=000, bin1=001, bin2=010, bin3=100), clear the latency counter, go to WAIT.
REQ-022 WAIT: hold bf_c for BF_LAT cycles, then go to CAPTURE. With BF_LAT=0, WAIT lasts 0 cycles and the FSM goes from SETUP directly to CAPTURE.
REQ-023 CAPTURE: latch bf_xro/bf_xio into result slot bin. If bin=3, go to DRAIN with out_idx=0; otherwise increment bin and go to SETUP.
REQ-024 bf_xr/bf_xi SHALL be driven from the operand registers continuously and remain stable from SETUP through the last CAPTURE.
REQ-025 DRAIN: out_valid=1, out_re/out_im = result[out_idx], out_bin = out_idx.
REQ-026 DRAIN: on out_ready, out_idx increments. The handshake on out_idx=3 pulses frame_done, increments frame_cnt (8-bit, wraps 255->0), clears ld_idx, and returns to LOAD.
REQ-027 DRAIN: while out_ready=0, out_valid, data and out_bin SHALL hold unchanged.
REQ-028 Results SHALL be stored and emitted unmodified at DW bits; the block performs no arithmetic.
REQ-029 bf_c SHALL be 000 outside SETUP, WAIT and CAPTURE.
REQ-030 Per frame, latency from the 4th input handshake to the first out_valid SHALL be 4*(BF_LAT+2)+1 cycles.

Reset
REQ-031 RST sampled high SHALL force: state LOAD, ld_idx/bin/out_idx = 0, operand and result registers = 0, frame_cnt = 0.
REQ-032 During and after reset, outputs SHALL be: in_ready=1 (after reset), out_valid=0, frame_done=0, busy=0, bf_c=000, bf_xr=bf_xi=0.
REQ-033 RST asserted in any state SHALL abort the frame with no frame_done pulse, and the partial frame SHALL be discarded.
REQ-034 RST has priority over any simultaneous handshake.

Structure
REQ-035 Package r4_fft_pkg SHALL hold the state enum, the bin-to-bf_c encoding function and the BIN_COUNT=4 constant.
REQ-036 One sub-module, r4_frame_buf, SHALL be used: a 4-entry by 2*DW register file with a write port and an asynchronous read port, instantiated twice (operand and result).
REQ-037 The butterfly SHALL be external and connected only through the bf_* ports.

Verification
REQ-038 Reset: assert RST mid-WAIT -> next cycle in_ready=1, out_valid=0, bf_c=000, frame_cnt=0, no frame_done.
REQ-039 Single frame: BF_LAT=1, inputs (1,0),(2,0),(3,0),(4,0), butterfly model out = bin*3 -> out_re sequence 0,3,6,9 with out_bin 0..3; first out_valid 13 cycles after the 4th handshake.
REQ-040 Bin select: bf_c observed as 000,001,010,100, each held for BF_LAT+2 cycles.
REQ-041 Backpressure: out_ready=0 for 5 cycles on out_idx=2 -> out_re/out_bin stable throughout, in_ready=0.
REQ-042 Wrap: run 256 frames -> frame_cnt returns to 0 with exactly 256 frame_done pulses.
REQ-043 Latency 0: BF_LAT=0, bursty in_valid (every other cycle) -> correct results, first out_valid 9 cycles after the 4th handshake.

Source files
------------

// File: rtl/r4_fft_pkg.sv
// Shared types and helpers for the sequential radix-4 butterfly frame controller.
package r4_fft_pkg;

    // Number of samples (and bins) in one radix-4 frame.
    localparam int BIN_COUNT = 4;

    // Controller states.
    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_SETUP   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // Butterfly bin select {c3,c2,c1}: one-hot for bins 1..3, all zero for bin 0.
    function automatic logic [2:0] bin_to_c(input logic [1:0] bin);
        case (bin)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/r4_frame_buf.sv
// Four-entry register file holding one frame of complex samples {im, re}.
// One write port, one asynchronous read port, plus a flat view of all entries.
module r4_frame_buf
    import r4_fft_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [1:0]                 waddr,
    input  logic [2*DW-1:0]            wdata,
    input  logic [1:0]                 raddr,
    output logic [2*DW-1:0]            rdata,
    output logic [BIN_COUNT*2*DW-1:0]  flat
);

    logic [2*DW-1:0] mem [BIN_COUNT];

    // Storage: cleared by reset, otherwise written one entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BIN_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    // Flat view: entry i occupies bits [i*2*DW +: 2*DW].
    always_comb begin
        flat = '0;
        for (int i = 0; i < BIN_COUNT; i++) begin
            flat[i*2*DW +: 2*DW] = mem[i];
        end
    end

endmodule

// File: rtl/r4_fft_seq.sv
// Sequential radix-4 frame controller: loads four samples, steps an external
// butterfly through bins 0..3, captures each result, then drains them in order.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and data until that edge; ready may be
// asserted independently of valid. out_valid, out_re/out_im and out_bin stay
// unchanged while out_ready is low.
module r4_fft_seq
    import r4_fft_pkg::*;
#(
    parameter int DW     = 4,
    parameter int BF_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_re,
    input  logic [DW-1:0]   in_im,
    output logic [4*DW-1:0] bf_xr,
    output logic [4*DW-1:0] bf_xi,
    output logic [2:0]      bf_c,
    input  logic [DW-1:0]   bf_xro,
    input  logic [DW-1:0]   bf_xio,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_re,
    output logic [DW-1:0]   out_im,
    output logic [1:0]      out_bin,
    output logic            busy,
    output logic            frame_done,
    output logic [7:0]      frame_cnt
);

    // Last value of the wait counter; WAIT is skipped entirely when BF_LAT is 0.
    localparam logic [2:0] LAT_LAST = 3'((BF_LAT > 0) ? (BF_LAT - 1) : 0);

    state_t     state;
    logic [1:0] ld_idx;
    logic [1:0] bin;
    logic [1:0] out_idx;
    logic [2:0] lat_cnt;

    logic                       in_fire;
    logic                       res_we;
    logic [2*DW-1:0]            res_rd;
    logic [2*DW-1:0]            op_rd;
    logic [BIN_COUNT*2*DW-1:0]  op_flat;
    logic [BIN_COUNT*2*DW-1:0]  res_flat;
    logic                       unused_sink;

    // in_ready is high only in LOAD, so a fire also implies the LOAD state.
    assign in_fire = in_valid & in_ready;
    assign res_we  = (state == S_CAPTURE);

    // Operand store: written by input handshakes, read as a whole by the butterfly.
    r4_frame_buf #(.DW(DW)) u_op_buf (
        .clk   (CLK),
        .rst   (RST),
        .we    (in_fire),
        .waddr (ld_idx),
        .wdata ({in_im, in_re}),
        .raddr (2'd0),
        .rdata (op_rd),
        .flat  (op_flat)
    );

    // Result store: written once per bin in CAPTURE, read by the drain index.
    r4_frame_buf #(.DW(DW)) u_res_buf (
        .clk   (CLK),
        .rst   (RST),
        .we    (res_we),
        .waddr (bin),
        .wdata ({bf_xio, bf_xro}),
        .raddr (out_idx),
        .rdata (res_rd),
        .flat  (res_flat)
    );

    // Only one port of each buffer is needed here.
    assign unused_sink = ^{op_rd, res_flat};

    // Operand slot g drives lane g of the butterfly buses.
    for (genvar g = 0; g < BIN_COUNT; g++) begin : g_lane
        assign bf_xr[g*DW +: DW] = op_flat[g*2*DW      +: DW];
        assign bf_xi[g*DW +: DW] = op_flat[g*2*DW + DW +: DW];
    end

    assign {out_im, out_re} = res_rd;
    assign out_bin          = out_idx;

    // Frame sequencer with registered handshake, status and bin-select outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_LOAD;
            ld_idx     <= 2'd0;
            bin        <= 2'd0;
            out_idx    <= 2'd0;
            lat_cnt    <= 3'd0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            bf_c       <= 3'b000;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        ld_idx <= ld_idx + 2'd1;
                        if (ld_idx == 2'd3) begin
                            state    <= S_SETUP;
                            bin      <= 2'd0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            bf_c     <= bin_to_c(2'd0);
                        end
                    end
                end
                S_SETUP: begin
                    lat_cnt <= 3'd0;
                    state   <= (BF_LAT == 0) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_CAPTURE: begin
                    if (bin == 2'd3) begin
                        state   <= S_DRAIN;
                        out_idx <= 2'd0;
                        bf_c    <= 3'b000;
                    end else begin
                        bin   <= bin + 2'd1;
                        bf_c  <= bin_to_c(bin + 2'd1);
                        state <= S_SETUP;
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle only raises out_valid; results then
                    // advance on each accepted transfer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (out_idx == 2'd3) begin
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            ld_idx     <= 2'd0;
                            in_ready   <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_LOAD;
                        end else begin
                            out_idx <= out_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r4_fft_seq.sv
// Bench for r4_fft_seq: instance 0 runs with BF_LAT=0, instance 1 with BF_LAT=1.
// Each instance talks to a butterfly model returning re = 3*bin and
// im = operand re of slot bin, delayed by that instance's BF_LAT.
module tb_r4_fft_seq;

    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;

    logic            in_valid   [2];
    logic            in_ready   [2];
    logic [DW-1:0]   in_re      [2];
    logic [DW-1:0]   in_im      [2];
    logic [4*DW-1:0] bf_xr      [2];
    logic [4*DW-1:0] bf_xi      [2];
    logic [2:0]      bf_c       [2];
    logic            out_valid  [2];
    logic            out_ready  [2];
    logic [DW-1:0]   out_re     [2];
    logic [DW-1:0]   out_im     [2];
    logic [1:0]      out_bin    [2];
    logic            busy       [2];
    logic            frame_done [2];
    logic [7:0]      frame_cnt  [2];

    int         total = 0;
    int         bad   = 0;
    int         pulses [2] = '{0, 0};
    logic [7:0] exp_fcnt [2];

    // Expected results {bin, im, re}, pushed when a frame is driven.
    logic [2*DW+1:0] exp_q [$];

    // Clock.
    always #5 clk = ~clk;

    // frame_done pulse counter per instance.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (frame_done[k] === 1'b1) pulses[k]++;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] xro, xio, m_re, m_im;
        int b;

        // Butterfly model decode.
        always_comb begin
            case (bf_c[g])
                3'b001:  b = 1;
                3'b010:  b = 2;
                3'b100:  b = 3;
                default: b = 0;
            endcase
            m_re = DW'(3 * b);
            m_im = bf_xr[g][b*DW +: DW];
        end

        if (g == 0) begin : g_comb
            assign xro = m_re;
            assign xio = m_im;
        end else begin : g_pipe
            always @(posedge clk) begin
                xro <= m_re;
                xio <= m_im;
            end
        end

        r4_fft_seq #(.DW(DW), .BF_LAT(g)) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_re      (in_re[g]),
            .in_im      (in_im[g]),
            .bf_xr      (bf_xr[g]),
            .bf_xi      (bf_xi[g]),
            .bf_c       (bf_c[g]),
            .bf_xro     (xro),
            .bf_xio     (xio),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_re     (out_re[g]),
            .out_im     (out_im[g]),
            .out_bin    (out_bin[g]),
            .busy       (busy[g]),
            .frame_done (frame_done[g]),
            .frame_cnt  (frame_cnt[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_c(input int b);
        case (b)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Offer one sample at a falling edge; returns one falling edge after the transfer.
    task automatic send(input int k, input logic [DW-1:0] re, input logic [DW-1:0] im);
        int guard;
        guard = 0;
        in_valid[k] = 1'b1;
        in_re[k]    = re;
        in_im[k]    = im;
        while (!in_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_seen", 32'(in_ready[k]), 32'd1);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic check_idle(input int k, input string tag);
        check({tag, "_in_ready"},   32'(in_ready[k]),   32'd1);
        check({tag, "_out_valid"},  32'(out_valid[k]),  32'd0);
        check({tag, "_frame_done"}, 32'(frame_done[k]), 32'd0);
        check({tag, "_busy"},       32'(busy[k]),       32'd0);
        check({tag, "_bf_c"},       32'(bf_c[k]),       32'd0);
        check({tag, "_frame_cnt"},  32'(frame_cnt[k]),  32'd0);
    endtask

    // Drive one frame, track the compute phase, then drain and score the results.
    task automatic run_frame(input int k, input logic [4*DW-1:0] xr, input logic [4*DW-1:0] xi,
                             input int gap, input int stall_at, input int stall_n);
        int hold;
        int cnt;
        logic [2*DW+1:0] e;
        hold = k + 2;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({2'(b), xr[b*DW +: DW], DW'(3 * b)});
        end
        for (int s = 0; s < 4; s++) begin
            send(k, xr[s*DW +: DW], xi[s*DW +: DW]);
            if (s < 3) repeat (gap) @(negedge clk);
        end
        cnt = 0;
        while (!out_valid[k] && cnt < 100) begin
            check("bf_c", 32'(bf_c[k]), (cnt < 4 * hold) ? 32'(exp_c(cnt / hold)) : 32'd0);
            check("busy_in_ready", {30'd0, busy[k], in_ready[k]}, 32'd2);
            check("bf_xr", 32'(bf_xr[k]), 32'(xr));
            check("bf_xi", 32'(bf_xi[k]), 32'(xi));
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, 4 * hold + 1);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                out_ready[k] = 1'b0;
                for (int j = 0; j < stall_n; j++) begin
                    check("stall_valid", 32'(out_valid[k]), 32'd1);
                    check("stall_data", {22'd0, out_bin[k], out_im[k], out_re[k]}, 32'(exp_q[0]));
                    check("stall_in_ready", 32'(in_ready[k]), 32'd0);
                    @(negedge clk);
                end
            end
            out_ready[k] = 1'b1;
            check("out_valid", 32'(out_valid[k]), 32'd1);
            e = exp_q.pop_front();
            check("out_data", {22'd0, out_bin[k], out_im[k], out_re[k]}, 32'(e));
            @(negedge clk);
        end
        out_ready[k] = 1'b0;
        exp_fcnt[k]  = exp_fcnt[k] + 8'd1;
        check("frame_done", 32'(frame_done[k]), 32'd1);
        check("frame_cnt", 32'(frame_cnt[k]), 32'(exp_fcnt[k]));
        check("post_out_valid", 32'(out_valid[k]), 32'd0);
        check("post_in_ready", 32'(in_ready[k]), 32'd1);
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done[k]), 32'd0);
    endtask

    initial begin
        int p;
        logic [4*DW-1:0] xr, xi;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_re[k]     = '0;
            in_im[k]     = '0;
            out_ready[k] = 1'b0;
            exp_fcnt[k]  = 8'd0;
        end

        // Reset and idle state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_idle(k, "in_reset");
            check("in_reset_bf_xr", 32'(bf_xr[k]), 32'd0);
            check("in_reset_bf_xi", 32'(bf_xi[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_idle(k, "after_reset");

        // Single frame on BF_LAT=1 with a 5-cycle stall on result 2.
        run_frame(1, {4'd4, 4'd3, 4'd2, 4'd1}, 16'd0, 0, 2, 5);

        // Reset during bin 1's WAIT aborts the frame.
        for (int s = 0; s < 4; s++) send(1, 4'(s + 5), 4'(s));
        repeat (4) @(negedge clk);
        check("pre_abort_bf_c", 32'(bf_c[1]), 32'b001);
        check("pre_abort_busy", 32'(busy[1]), 32'd1);
        p = pulses[1];
        rst = 1'b1;
        @(negedge clk);
        check_idle(1, "abort");
        check("abort_bf_xr", 32'(bf_xr[1]), 32'd0);
        rst = 1'b0;
        exp_fcnt[0] = 8'd0;
        exp_fcnt[1] = 8'd0;
        repeat (3) @(negedge clk);
        check("abort_no_done", pulses[1] - p, 0);
        check_idle(1, "abort_after");

        // BF_LAT=0 with input valid every other cycle.
        xr = 16'($urandom_range(0, 16'hffff));
        xi = 16'($urandom_range(0, 16'hffff));
        run_frame(0, xr, xi, 1, 4, 0);

        // Frame counter wrap over 256 frames.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_fcnt[0] = 8'd0;
        exp_fcnt[1] = 8'd0;
        @(negedge clk);
        p = pulses[0];
        for (int f = 0; f < 256; f++) begin
            xr = 16'($urandom_range(0, 16'hffff));
            xi = 16'($urandom_range(0, 16'hffff));
            run_frame(0, xr, xi, 0, (f % 7 == 3) ? 1 : 4, 2);
        end
        check("wrap_frame_cnt", 32'(frame_cnt[0]), 32'd0);
        check("wrap_pulses", pulses[0] - p, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
